// File: rtl/zbuf_fill_arbiter_pkg.sv
// Shared types for the z-buffer fill arbiter: FSM states, grant index, age width.
package zbuf_arb_pkg;

    localparam int AGE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    typedef logic [1:0]       grant_idx_t;
    typedef logic [AGE_W-1:0] age_t;

endpackage

// File: rtl/zbuf_fill_arbiter_if.sv
// FIFO-side and z-buffer-side signals of the fill arbiter.
// master: the arbiter. slave: the FIFOs / z-buffer environment.
interface zbuf_fill_arbiter_if #(
    parameter int MEM_LENGTH  = 8,
    parameter int PIXEL_WIDTH = 16
);
    logic [MEM_LENGTH-1:0]  fill_1, fill_2, fill_3, fill_4;
    logic [PIXEL_WIDTH-1:0] pix_in_1, pix_in_2, pix_in_3, pix_in_4;
    logic                   ack_1, ack_2, ack_3, ack_4;
    logic                   req_1, req_2, req_3, req_4;
    logic                   rdy_z_buffer;
    logic                   send_z_buffer;
    logic [PIXEL_WIDTH-1:0] pix_out;
    logic [1:0]             grant_id;

    modport master (
        input  fill_1, fill_2, fill_3, fill_4,
        input  pix_in_1, pix_in_2, pix_in_3, pix_in_4,
        input  ack_1, ack_2, ack_3, ack_4,
        input  rdy_z_buffer,
        output req_1, req_2, req_3, req_4,
        output send_z_buffer, pix_out, grant_id
    );

    modport slave (
        output fill_1, fill_2, fill_3, fill_4,
        output pix_in_1, pix_in_2, pix_in_3, pix_in_4,
        output ack_1, ack_2, ack_3, ack_4,
        output rdy_z_buffer,
        input  req_1, req_2, req_3, req_4,
        input  send_z_buffer, pix_out, grant_id
    );
endinterface

// File: rtl/zbuf_fill_arbiter_select.sv
// Combinational winner selection: largest fill wins, ties go to the first
// candidate in round-robin order starting after the last grant. When USE_AGE
// is set, any eligible FIFO whose age reached STARVE_LIMIT pre-empts the fill
// ranking, starved FIFOs being taken in plain round-robin order.
module zbuf_arb_select
    import zbuf_arb_pkg::*;
#(
    parameter int MEM_LENGTH   = 8,
    parameter int STARVE_LIMIT = 15,
    parameter bit USE_AGE      = 1'b0
) (
    input  logic [MEM_LENGTH-1:0] fills [4],
    input  age_t                  ages  [4],
    input  grant_idx_t            rr_last,
    output grant_idx_t            winner,
    output logic                  valid
);
    localparam age_t LIMIT = age_t'(STARVE_LIMIT);

    grant_idx_t            rr_start;
    grant_idx_t            idx;
    grant_idx_t            starved_idx;
    logic                  starved;
    logic [MEM_LENGTH-1:0] best;

    // Scan the four FIFOs in round-robin order; strict '>' keeps the earliest tie.
    always_comb begin
        rr_start    = rr_last + 2'd1;
        idx         = rr_start;
        winner      = rr_start;
        valid       = 1'b0;
        best        = '0;
        starved     = 1'b0;
        starved_idx = rr_start;
        for (int k = 0; k < 4; k++) begin
            idx = rr_start + grant_idx_t'(k);
            if (fills[idx] != '0) begin
                if (!valid || fills[idx] > best) begin
                    valid  = 1'b1;
                    best   = fills[idx];
                    winner = idx;
                end
                if (USE_AGE && !starved && ages[idx] >= LIMIT) begin
                    starved     = 1'b1;
                    starved_idx = idx;
                end
            end
        end
        if (starved) begin
            winner = starved_idx;
        end
    end

endmodule

// File: rtl/zbuf_fill_arbiter.sv
// Four-FIFO to z-buffer fill arbiter. IDLE picks a winner, REQ pops one pixel
// from the granted FIFO, SEND holds it until the z-buffer takes it.
// Optional anti-starvation ageing is enabled by defining ZBUF_ARB_STARVE_EN.
//
// state | meaning
// IDLE  | no transfer; grant the best non-empty FIFO if any
// REQ   | req to granted FIFO, waiting for its ack (fills ignored)
// SEND  | pixel presented to z-buffer, waiting for rdy_z_buffer
module zbuf_fill_arbiter
    import zbuf_arb_pkg::*;
#(
    parameter int MEM_LENGTH   = 8,
    parameter int PIXEL_WIDTH  = 16,
    parameter int STARVE_LIMIT = 15
) (
    input logic                clk,
    input logic                reset,
    zbuf_fill_arbiter_if.master bus
);
`ifdef ZBUF_ARB_STARVE_EN
    localparam bit   USE_AGE   = 1'b1;
    localparam age_t LIMIT_AGE = age_t'(STARVE_LIMIT);
`else
    localparam bit   USE_AGE   = 1'b0;
`endif

    logic [MEM_LENGTH-1:0]  fills  [4];
    logic [PIXEL_WIDTH-1:0] pix_in [4];
    logic [3:0]             ack_v;
    age_t                   ages   [4];

    state_t                 state;
    grant_idx_t             grant;
    logic [3:0]             req_q;
    logic                   send_q;
    logic [PIXEL_WIDTH-1:0] pix_q;

    grant_idx_t             sel_win;
    logic                   sel_valid;

    assign fills[0]  = bus.fill_1;
    assign fills[1]  = bus.fill_2;
    assign fills[2]  = bus.fill_3;
    assign fills[3]  = bus.fill_4;
    assign pix_in[0] = bus.pix_in_1;
    assign pix_in[1] = bus.pix_in_2;
    assign pix_in[2] = bus.pix_in_3;
    assign pix_in[3] = bus.pix_in_4;
    assign ack_v     = {bus.ack_4, bus.ack_3, bus.ack_2, bus.ack_1};

`ifdef ZBUF_ARB_STARVE_EN
    age_t age_q [4];
    assign ages = age_q;
`else
    assign ages[0] = '0;
    assign ages[1] = '0;
    assign ages[2] = '0;
    assign ages[3] = '0;
`endif

    zbuf_arb_select #(
        .MEM_LENGTH  (MEM_LENGTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .USE_AGE     (USE_AGE)
    ) u_select (
        .fills  (fills),
        .ages   (ages),
        .rr_last(grant),
        .winner (sel_win),
        .valid  (sel_valid)
    );

    // Arbiter FSM; every output is a register so the FIFOs and z-buffer see clean levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= 2'd3;
            req_q  <= '0;
            send_q <= 1'b0;
            pix_q  <= '0;
`ifdef ZBUF_ARB_STARVE_EN
            for (int i = 0; i < 4; i++) begin
                age_q[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant <= sel_win;
                        req_q <= 4'(1) << sel_win;
                        state <= REQ;
`ifdef ZBUF_ARB_STARVE_EN
                        for (int i = 0; i < 4; i++) begin
                            if (grant_idx_t'(i) == sel_win) begin
                                age_q[i] <= '0;
                            end else if (fills[i] != '0 && age_q[i] < LIMIT_AGE) begin
                                age_q[i] <= age_q[i] + age_t'(1);
                            end
                        end
`endif
                    end
                end
                REQ: begin
                    if (ack_v[grant]) begin
                        pix_q  <= pix_in[grant];
                        req_q  <= '0;
                        send_q <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.rdy_z_buffer) begin
                        send_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    req_q  <= '0;
                    send_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_1         = req_q[0];
    assign bus.req_2         = req_q[1];
    assign bus.req_3         = req_q[2];
    assign bus.req_4         = req_q[3];
    assign bus.send_z_buffer = send_q;
    assign bus.pix_out       = pix_q;
    assign bus.grant_id      = grant;

endmodule

// File: doc/zbuf_fill_arbiter.md
ZBUF_FILL_ARBITER -- requirements
Module: zbuf_fill_arbiter

Interface
REQ-001 SHALL have parameter MEM_LENGTH, default 8, fill-level width.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 16, pixel width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15, grants lost before forced priority (1..15).
REQ-004 SHALL have port clk, input, 1, single rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have ports fill_1..fill_4, input, MEM_LENGTH each, unsigned FIFO occupancy; 0 means empty.
REQ-007 SHALL have ports pix_in_1..pix_in_4, input, PIXEL_WIDTH each, FIFO head pixel, valid with matching ack.
REQ-008 SHALL have ports ack_1..ack_4, input, 1 each, FIFO pop acknowledge.
REQ-009 SHALL have ports req_1..req_4, output, 1 each, pop request to FIFO i.
REQ-010 SHALL have port rdy_z_buffer, input, 1, z-buffer accepts pixel this cycle.
REQ-011 SHALL have port send_z_buffer, output, 1, pix_out valid.
REQ-012 SHALL have port pix_out, output, PIXEL_WIDTH, pixel to z-buffer.
REQ-013 SHALL have port grant_id, output, 2, index (0..3) of last/current grant.

Function
REQ-014 SHALL implement FSM IDLE, REQ, SEND; all outputs registered.
REQ-015 IDLE: eligible = fill_i != 0; if any eligible, latch winner into grant_id, go to REQ next edge; else stay IDLE.
REQ-016 Winner: largest fill; ties resolved round-robin starting at index (last grant + 1) mod 4.
REQ-017 REQ: req_<grant> high, all other req low; grant locked, fill changes ignored; stay until ack_<grant>.
REQ-018 On ack_<grant> in REQ: capture pix_in_<grant> into pix_out, drop req, go to SEND; latency ack-edge to send_z_buffer high = 1 cycle.
REQ-019 Acks on non-granted lines, or any ack outside REQ, SHALL be ignored.
REQ-020 SEND: send_z_buffer high, pix_out stable until edge with rdy_z_buffer=1; then send_z_buffer low, go IDLE.
REQ-021 rdy_z_buffer outside SEND SHALL be ignored; minimum throughput one pixel per 3 cycles.

Reset
REQ-022 reset low SHALL asynchronously force IDLE, req_1..4=0, send_z_buffer=0, pix_out=0, grant_id=3 (so first RR start is 0), all age counters 0, from any state including mid-REQ/SEND.

Configuration
REQ-023 Macro ZBUF_ARB_STARVE_EN defined: per-FIFO 4-bit saturating age; on each grant, every other eligible FIFO ages +1 (saturate STARVE_LIMIT), granted FIFO clears to 0.
REQ-024 With ZBUF_ARB_STARVE_EN: any eligible FIFO at STARVE_LIMIT overrides fill ranking; multiple starved resolved round-robin per REQ-016.
REQ-025 Without ZBUF_ARB_STARVE_EN: no age registers; pure REQ-016 selection.

Structure
REQ-026 Package zbuf_arb_pkg SHALL hold state enum (IDLE, REQ, SEND), 2-bit grant index type, age width constant 4.
REQ-027 Selection logic SHALL be a combinational sub-module zbuf_arb_select (fills, ages, RR pointer -> winner index, valid).

Verification
REQ-028 fills (0,0,0,0) 20 cycles -> req all 0, send_z_buffer 0, FSM IDLE.
REQ-029 fills (2,5,1,0), ack_2 one cycle after req_2, pix_in_2=16'hBEEF, rdy=1 -> req_2 only, send_z_buffer next cycle, pix_out=16'hBEEF, grant_id=1.
REQ-030 fills (4,4,4,4) constant, immediate ack/rdy, 8 transfers -> grant_id sequence 0,1,2,3,0,1,2,3.
REQ-031 rdy_z_buffer held 0 for 10 cycles in SEND, pix_out=16'h1234 -> send_z_buffer and pix_out stable 10 cycles, ack_3 pulses ignored.
REQ-032 ZBUF_ARB_STARVE_EN, STARVE_LIMIT=3, fill_1=8 refilled, fill_4=1 -> FIFO 4 granted on 4th grant; without macro FIFO 4 never granted.
REQ-033 reset low mid-SEND -> same cycle send_z_buffer=0, pix_out=0, req all 0; after release first grant starts RR at index 0.
